// File: rtl/speaker_arb_pkg.sv
// speaker_arb_pkg
// Shared types and helpers for the speaker arbiter.
//   SAMPLE_W    : width of one audio sample (signed, two's complement)
//   MAX_REQ     : widest request vector the winner helper accepts
//   state_t     : arbiter states IDLE / PLAY / MUTE
//   winner_t    : {valid, idx} result of the priority pick
//   pick_winner : lowest set index of a request vector (index 0 wins)
package speaker_arb_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned MAX_REQ  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    MUTE = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } winner_t;

  function automatic winner_t pick_winner(input logic [MAX_REQ-1:0] req);
    winner_t w;
    w = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (req[i] && !w.valid) begin
        w.valid = 1'b1;
        w.idx   = i[4:0];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/speaker_frame_timer.sv
// speaker_frame_timer
// Free-running frame counter, kept in lock-step with the I2S speaker
// controller's counter (same clock, same reset).
//   clk        : system clock
//   rst        : asynchronous, active-high reset (counter restarts at 0)
//   frame_tick : one-cycle pulse on the last clk of each frame
module speaker_frame_timer #(
  parameter int unsigned FRAME_CYCLES = 512
) (
  input  logic clk,
  input  logic rst,
  output logic frame_tick
);

  localparam int unsigned CW = $clog2(FRAME_CYCLES);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign frame_tick = (r_count == CW'(FRAME_CYCLES - 1));

endmodule

// File: rtl/speaker_arbiter.sv
// speaker_arbiter
// Fixed-priority owner selection for the single stereo speaker path, with a
// minimum hold time and a muted gap on every owner change. All grant and
// sample updates happen on frame_tick so they line up with frame boundaries.
// Optional build macro: SPEAKER_ARB_VOLUME_EN adds a 3-bit vol input that
// arithmetically right-shifts the owner's samples.
//   clk, rst              : clock, asynchronous active-high reset
//   req[NUM_REQ]          : request levels, sampled on frame_tick only
//   src_left/src_right    : flattened 16-bit samples, source i at [16i+15:16i]
//   vol[3] (optional)     : attenuation shift, sampled with the sample
//   grant[NUM_REQ]        : one-hot owner, zero when no owner
//   busy                  : high in PLAY or MUTE
//   frame_tick            : pulse on the last clk of each frame
//   audio_left/right      : samples to the speaker controller
module speaker_arbiter
  import speaker_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned FRAME_CYCLES    = 512,
  parameter int unsigned MIN_HOLD_FRAMES = 64,
  parameter int unsigned GAP_FRAMES      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [SAMPLE_W*NUM_REQ-1:0]   src_left,
  input  logic [SAMPLE_W*NUM_REQ-1:0]   src_right,
`ifdef SPEAKER_ARB_VOLUME_EN
  input  logic [2:0]                    vol,
`endif
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          frame_tick,
  output logic [SAMPLE_W-1:0]           audio_left,
  output logic [SAMPLE_W-1:0]           audio_right
);

  localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HW = (MIN_HOLD_FRAMES > 0) ? $clog2(MIN_HOLD_FRAMES + 1) : 1;
  localparam int unsigned GW = $clog2(GAP_FRAMES + 1);

  state_t               r_state;
  logic [OW-1:0]        r_owner;
  logic [HW-1:0]        r_hold;
  logic [GW-1:0]        r_gap;
  logic [NUM_REQ-1:0]   r_grant;
  logic [SAMPLE_W-1:0]  r_left;
  logic [SAMPLE_W-1:0]  r_right;

  logic                 w_tick;
  logic [MAX_REQ-1:0]   w_req_ext;
  winner_t              w_win;
  logic [OW-1:0]        w_win_idx;
  logic [NUM_REQ-1:0]   w_win_onehot;
  logic [SAMPLE_W-1:0]  w_src_l [NUM_REQ];
  logic [SAMPLE_W-1:0]  w_src_r [NUM_REQ];
  logic [SAMPLE_W-1:0]  w_new_l, w_new_r, w_own_l, w_own_r;
  logic                 w_release;

`ifdef SPEAKER_ARB_VOLUME_EN
  function automatic logic [SAMPLE_W-1:0] attenuate(input logic [SAMPLE_W-1:0] s);
    return $signed(s) >>> vol;
  endfunction
`else
  function automatic logic [SAMPLE_W-1:0] attenuate(input logic [SAMPLE_W-1:0] s);
    return s;
  endfunction
`endif

  speaker_frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(w_tick)
  );

  always_comb begin
    w_req_ext = '0;
    w_req_ext[NUM_REQ-1:0] = req;
    w_win = pick_winner(w_req_ext);
  end

  assign w_win_idx    = OW'(w_win.idx);
  assign w_win_onehot = NUM_REQ'(1) << w_win_idx;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_src_l[i] = src_left[i*SAMPLE_W +: SAMPLE_W];
      w_src_r[i] = src_right[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  assign w_new_l = attenuate(w_src_l[w_win_idx]);
  assign w_new_r = attenuate(w_src_r[w_win_idx]);
  assign w_own_l = attenuate(w_src_l[r_owner]);
  assign w_own_r = attenuate(w_src_r[r_owner]);

  // Owner drop always wins over preemption; both take the same muted exit.
  assign w_release = !req[r_owner] ||
                     (w_win.valid && (w_win_idx < r_owner) && (r_hold == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_hold  <= '0;
      r_gap   <= '0;
      r_grant <= '0;
      r_left  <= '0;
      r_right <= '0;
    end else if (w_tick) begin
      case (r_state)
        IDLE: begin
          if (w_win.valid) begin
            r_state <= PLAY;
            r_owner <= w_win_idx;
            r_grant <= w_win_onehot;
            r_hold  <= HW'(MIN_HOLD_FRAMES);
            r_left  <= w_new_l;
            r_right <= w_new_r;
          end
        end
        PLAY: begin
          if (r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
          end
          if (w_release) begin
            r_state <= MUTE;
            r_grant <= '0;
            r_left  <= '0;
            r_right <= '0;
            r_gap   <= GW'(GAP_FRAMES - 1);
          end else begin
            r_left  <= w_own_l;
            r_right <= w_own_r;
          end
        end
        MUTE: begin
          if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
          end else if (w_win.valid) begin
            r_state <= PLAY;
            r_owner <= w_win_idx;
            r_grant <= w_win_onehot;
            r_hold  <= HW'(MIN_HOLD_FRAMES);
            r_left  <= w_new_l;
            r_right <= w_new_r;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign busy        = (r_state != IDLE);
  assign frame_tick  = w_tick;
  assign audio_left  = r_left;
  assign audio_right = r_right;

endmodule

// File: tb/tb_speaker_arbiter.sv
module tb_speaker_arbiter;

  localparam int F = 32;
  localparam int H = 6;
  localparam int G = 2;
  localparam int N = 4;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_MUTE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] src_left = '0;
  logic [63:0] src_right = '0;
  logic [2:0]  vol = '0;
  logic [2:0]  vol_eff;
  logic [3:0]  grant;
  logic        busy, frame_tick;
  logic [15:0] audio_left, audio_right;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  speaker_arbiter #(
    .NUM_REQ        (N),
    .FRAME_CYCLES   (F),
    .MIN_HOLD_FRAMES(H),
    .GAP_FRAMES     (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .src_left   (src_left),
    .src_right  (src_right),
`ifdef SPEAKER_ARB_VOLUME_EN
    .vol        (vol),
`endif
    .grant      (grant),
    .busy       (busy),
    .frame_tick (frame_tick),
    .audio_left (audio_left),
    .audio_right(audio_right)
  );

`ifdef SPEAKER_ARB_VOLUME_EN
  assign vol_eff = vol;
`else
  assign vol_eff = 3'd0;
`endif

  // ---------------- frame-level reference model ----------------
  typedef struct {
    int          cnt;
    int          mode;
    int          owner;
    int          played;
    int          muted;
    logic [3:0]  grant;
    logic [15:0] l;
    logic [15:0] r;
  } model_t;

  model_t m;

  // Attenuation as floor division by 2^v.
  function automatic logic [15:0] att(input logic [15:0] s, input logic [2:0] v);
    int x = $signed(s);
    int d = 1 << v;
    int q;
    if (x >= 0) q = x / d;
    else        q = -((-x + d - 1) / d);
    return q[15:0];
  endfunction

  function automatic model_t mreset();
    model_t s;
    s.cnt = 0; s.mode = M_IDLE; s.owner = 0; s.played = 0; s.muted = 0;
    s.grant = '0; s.l = '0; s.r = '0;
    return s;
  endfunction

  function automatic model_t grant_to(input model_t s, input int w, input logic [63:0] sl,
                                      input logic [63:0] sr, input logic [2:0] v);
    s.mode = M_PLAY; s.owner = w; s.played = 0;
    s.grant = '0; s.grant[w] = 1'b1;
    s.l = att(sl[16*w +: 16], v);
    s.r = att(sr[16*w +: 16], v);
    return s;
  endfunction

  function automatic model_t mstep(input model_t s, input logic [3:0] rq, input logic [63:0] sl,
                                   input logic [63:0] sr, input logic [2:0] v);
    model_t n = s;
    int win = -1;
    if (s.cnt == F - 1) begin
      for (int i = 0; i < N; i++) if (rq[i] && win < 0) win = i;
      case (s.mode)
        M_IDLE: if (win >= 0) n = grant_to(n, win, sl, sr, v);
        M_PLAY: begin
          n.played = s.played + 1;
          n.l = att(sl[16*s.owner +: 16], v);
          n.r = att(sr[16*s.owner +: 16], v);
          if (!rq[s.owner] || (win >= 0 && win < s.owner && n.played > H)) begin
            n.mode = M_MUTE; n.grant = '0; n.l = '0; n.r = '0; n.muted = 0;
          end
        end
        M_MUTE: begin
          n.muted = s.muted + 1;
          if (n.muted >= G) begin
            if (win >= 0) n = grant_to(n, win, sl, sr, v);
            else          n.mode = M_IDLE;
          end
        end
        default: ;
      endcase
    end
    n.cnt = (s.cnt + 1) % F;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= mreset();
    else     m <= mstep(m, req, src_left, src_right, vol_eff);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("model_tick",  {31'd0, frame_tick}, {31'd0, (m.cnt == F - 1)});
      chk("model_grant", {28'd0, grant}, {28'd0, m.grant});
      chk("model_busy",  {31'd0, busy}, {31'd0, (m.mode != M_IDLE)});
      chk("model_left",  {16'd0, audio_left}, {16'd0, m.l});
      chk("model_right", {16'd0, audio_right}, {16'd0, m.r});
    end
  end

  // Drive req, run to just after the next frame boundary, sample at negedge.
  task automatic step_frame(input logic [3:0] rv);
    int k = 0;
    req = rv;
    while (m.cnt != F - 1 && k < 2 * F) begin
      @(negedge clk);
      k++;
    end
    chk("pre_tick", {31'd0, frame_tick}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Count clk edges from now until frame_tick is seen.
  task automatic measure_tick(input string nm, input int exp);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 2 * F) begin
      @(posedge clk);
      #1;
      n++;
      seen = frame_tick;
    end
    chk(nm, n, exp);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        busy;
    logic [15:0] l;
    logic [15:0] r;
  } vec_t;

  vec_t tbl[20];

  initial begin
    // frame-by-frame: request applied before the tick, outputs after it
    tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{4'b0100, 4'b0100, 1'b1, 16'h1234, 16'hABCD};
    tbl[2]  = '{4'b0100, 4'b0100, 1'b1, 16'h1234, 16'hABCD};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b1, 16'h0000, 16'h0000};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b1, 16'h0000, 16'h0000};
    tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 16'h0000, 16'h0000};
    tbl[6]  = '{4'b1000, 4'b1000, 1'b1, 16'h4444, 16'hC004};
    tbl[7]  = '{4'b1010, 4'b1000, 1'b1, 16'h4444, 16'hC004};
    tbl[8]  = '{4'b1010, 4'b1000, 1'b1, 16'h4444, 16'hC004};
    tbl[9]  = '{4'b1010, 4'b1000, 1'b1, 16'h4444, 16'hC004};
    tbl[10] = '{4'b1010, 4'b1000, 1'b1, 16'h4444, 16'hC004};
    tbl[11] = '{4'b1010, 4'b1000, 1'b1, 16'h4444, 16'hC004};
    tbl[12] = '{4'b1010, 4'b1000, 1'b1, 16'h4444, 16'hC004};
    tbl[13] = '{4'b1010, 4'b0000, 1'b1, 16'h0000, 16'h0000};
    tbl[14] = '{4'b0010, 4'b0000, 1'b1, 16'h0000, 16'h0000};
    tbl[15] = '{4'b0010, 4'b0010, 1'b1, 16'h2222, 16'h9002};
    tbl[16] = '{4'b1011, 4'b0010, 1'b1, 16'h2222, 16'h9002};
    tbl[17] = '{4'b0001, 4'b0000, 1'b1, 16'h0000, 16'h0000};
    tbl[18] = '{4'b0011, 4'b0000, 1'b1, 16'h0000, 16'h0000};
    tbl[19] = '{4'b0110, 4'b0010, 1'b1, 16'h2222, 16'h9002};

    src_left  = {16'h4444, 16'h1234, 16'h2222, 16'h1111};
    src_right = {16'hC004, 16'hABCD, 16'h9002, 16'h8001};

    // reset state and first/second tick timing
    repeat (2) @(negedge clk);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_left",  {16'd0, audio_left}, 32'd0);
    rst = 1'b0;
    chk_on = 1'b1;
    measure_tick("first_tick_cycles", F - 1);
    measure_tick("second_tick_cycles", F);
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      step_frame(tbl[i].req);
      chk($sformatf("tbl%0d_grant", i), {28'd0, grant}, {28'd0, tbl[i].grant});
      chk($sformatf("tbl%0d_busy", i),  {31'd0, busy}, {31'd0, tbl[i].busy});
      chk($sformatf("tbl%0d_left", i),  {16'd0, audio_left}, {16'd0, tbl[i].l});
      chk($sformatf("tbl%0d_right", i), {16'd0, audio_right}, {16'd0, tbl[i].r});
    end

    // asynchronous reset mid-frame while playing
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_grant", {28'd0, grant}, 32'd0);
    chk("arst_busy",  {31'd0, busy}, 32'd0);
    chk("arst_left",  {16'd0, audio_left}, 32'd0);
    chk("arst_right", {16'd0, audio_right}, 32'd0);
    chk("arst_tick",  {31'd0, frame_tick}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    measure_tick("arst_tick_cycles", F - 1);
    @(negedge clk);

    // randomized traffic against the model
    req = 4'b0100;
    for (int c = 0; c < 300 * F; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) src_left  = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) src_right = {$urandom, $urandom};
      if ($urandom_range(0, 31) == 0) vol = 3'($urandom_range(0, 7));
    end

`ifdef SPEAKER_ARB_VOLUME_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vol = 3'd3;
    src_left[15:0]  = 16'h8000;
    src_right[15:0] = 16'h7FF0;
    step_frame(4'b0001);
    chk("vol_neg", {16'd0, audio_left}, 32'h0000F000);
    chk("vol_pos", {16'd0, audio_right}, 32'h00000FFE);
`endif

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
